// File: rtl/uart_rx_fifo_v2.sv
// UART receive path: 2-FF line synchroniser, oversampling frame FSM with parity, stop and break
// checking, and a first-word-fall-through FIFO whose entries carry per-word error tags.
module uart_rx_fifo_v2 #(
   parameter  int D_W       = 8,
   parameter  int B_TICK    = 16,
   parameter  int DEPTH     = 64,
   parameter  int STOP_BITS = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           b_tick,
   output logic           b_en,
   input  logic           rx_en,
   input  logic           rx_data,
   input  logic [1:0]     par_mode,
   input  logic           rd_en,
   output logic [D_W-1:0] rd_data,
   output logic           rd_perr,
   output logic           rd_ferr,
   output logic           ff_empty,
   output logic           ff_full,
   output logic [AW:0]    ff_count,
   output logic           ovr_err,
   input  logic           ovr_clr,
   output logic           brk_det,
   output logic           busy,
   output logic [2:0]     dbg_state
);

   localparam int TW = $clog2(B_TICK);
   localparam int BW = $clog2(D_W);
   localparam int EW = D_W + 2;
   localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(B_TICK / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BRK    = 3'd5
   } state_t;

   state_t          state_q, state_n;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic [TW-1:0]   tick_q, tick_n;
   logic [BW-1:0]   bit_q, bit_n;
   logic [D_W-1:0]  data_q, data_n;
   logic            pbit_q, pbit_n;
   logic [1:0]      pmode_q, pmode_n;
   logic            ferr_q, ferr_n;
   logic            stop_q, stop_n;
   logic            tick_last, par_en, par_odd;
   logic            stop_smp, brk_hit, push;
   logic            ferr_w, perr_w;

   // Two flops bring the asynchronous line into the clock domain; idle-high reset value
   // keeps a reset release from looking like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b11;
         b_en   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rx_data};
         b_en   <= rx_en;
      end
   end

   assign rx_s      = sync_q[1];
   assign tick_last = b_tick && (tick_q == TICK_LAST);
   assign par_en    = pmode_q[0] ^ pmode_q[1];
   assign par_odd   = (pmode_q == 2'b10);
   assign ferr_w    = ferr_q | ~rx_s;
   assign perr_w    = par_en & (par_odd ? ~^{data_q, pbit_q} : ^{data_q, pbit_q});

   // State register with the frame datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         pbit_q  <= 1'b0;
         pmode_q <= 2'b00;
         ferr_q  <= 1'b0;
         stop_q  <= 1'b0;
         brk_det <= 1'b0;
      end else begin
         state_q <= state_n;
         tick_q  <= tick_n;
         bit_q   <= bit_n;
         data_q  <= data_n;
         pbit_q  <= pbit_n;
         pmode_q <= pmode_n;
         ferr_q  <= ferr_n;
         stop_q  <= stop_n;
         brk_det <= brk_hit;
      end
   end

   // Next-state logic; counters only move on b_tick.
   always_comb begin
      state_n = state_q;
      tick_n  = tick_q;
      bit_n   = bit_q;
      data_n  = data_q;
      pbit_n  = pbit_q;
      pmode_n = pmode_q;
      ferr_n  = ferr_q;
      stop_n  = stop_q;
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_n = S_START;
               tick_n  = '0;
               pmode_n = par_mode;
            end
         end
         S_START: begin
            if (b_tick) begin
               if (tick_q == HALF_LAST) begin
                  tick_n  = '0;
                  bit_n   = '0;
                  state_n = rx_s ? S_IDLE : S_DATA;
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (b_tick) begin
               if (tick_last) begin
                  tick_n = '0;
                  data_n = {rx_s, data_q[D_W-1:1]};
                  if (bit_q == BIT_LAST) begin
                     state_n = par_en ? S_PARITY : S_STOP;
                     pbit_n  = 1'b0;
                     ferr_n  = 1'b0;
                     stop_n  = 1'b0;
                  end else begin
                     bit_n = bit_q + 1'b1;
                  end
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (b_tick) begin
               if (tick_last) begin
                  tick_n  = '0;
                  pbit_n  = rx_s;
                  state_n = S_STOP;
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (b_tick) begin
               if (tick_last) begin
                  tick_n = '0;
                  ferr_n = ferr_w;
                  stop_n = stop_q + 1'b1;
                  if (brk_hit)                 state_n = S_BRK;
                  else if (stop_q == STOP_LAST) state_n = S_IDLE;
               end else begin
                  tick_n = tick_q + 1'b1;
               end
            end
         end
         S_BRK: begin
            if (rx_s) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      // Disabling the receiver abandons whatever frame is in flight.
      if (!rx_en) state_n = S_IDLE;
   end

   // Output logic: break is an all-zero frame whose first stop sample is also low.
   always_comb begin
      stop_smp  = rx_en && (state_q == S_STOP) && tick_last;
      brk_hit   = stop_smp && !stop_q && (data_q == '0) && !pbit_q && !rx_s;
      push      = stop_smp && !brk_hit && (stop_q == STOP_LAST);
      busy      = (state_q != S_IDLE);
      dbg_state = state_q;
   end

   // FIFO read side: rd_en is a pop request qualified by !ff_empty; the head word is
   // valid whenever ff_empty is low and a pop takes effect on the same rising edge.
   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [EW-1:0] head;
   logic          do_pop, do_push;

   assign ff_empty = (wr_ptr == rd_ptr);
   assign ff_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign ff_count = wr_ptr - rd_ptr;
   assign do_pop   = rd_en && !ff_empty;
   assign do_push  = push && (!ff_full || do_pop);
   assign head     = mem[rd_ptr[AW-1:0]];
   assign rd_data  = ff_empty ? '0   : head[D_W-1:0];
   assign rd_perr  = ff_empty ? 1'b0 : head[D_W];
   assign rd_ferr  = ff_empty ? 1'b0 : head[D_W+1];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= {ferr_w, perr_w, data_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ovr_err <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && ff_full && !do_pop) ovr_err <= 1'b1;
         else if (ovr_clr)               ovr_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_v2.sv
// Randomised frame-level bench for uart_rx_fifo_v2 with a queue-based reference of the FIFO,
// error tags, overrun flag and break pulses.
module tb_uart_rx_fifo_v2;

   localparam int D_W       = 8;
   localparam int B_TICK    = 16;
   localparam int DEPTH     = 64;
   localparam int STOP_BITS = 1;
   localparam int AW        = 6;
   localparam int TDIV      = 2;
   localparam int BIT_CLKS  = B_TICK * TDIV;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           b_tick = 1'b0;
   logic           rx_en = 1'b0;
   logic           rx_data = 1'b1;
   logic [1:0]     par_mode = 2'b00;
   logic           rd_en = 1'b0;
   logic           ovr_clr = 1'b0;
   logic           b_en, rd_perr, rd_ferr, ff_empty, ff_full, ovr_err, brk_det, busy;
   logic [D_W-1:0] rd_data;
   logic [AW:0]    ff_count;
   logic [2:0]     dbg_state;

   logic [D_W+1:0] exp_q[$];
   logic           exp_ovr = 1'b0;
   int             exp_brk = 0;
   int             brk_seen = 0;
   int             n_chk = 0;
   int             n_bad = 0;

   uart_rx_fifo_v2 #(.D_W(D_W), .B_TICK(B_TICK), .DEPTH(DEPTH), .STOP_BITS(STOP_BITS)) dut (
      .clk(clk), .rst(rst), .b_tick(b_tick), .b_en(b_en), .rx_en(rx_en), .rx_data(rx_data),
      .par_mode(par_mode), .rd_en(rd_en), .rd_data(rd_data), .rd_perr(rd_perr),
      .rd_ferr(rd_ferr), .ff_empty(ff_empty), .ff_full(ff_full), .ff_count(ff_count),
      .ovr_err(ovr_err), .ovr_clr(ovr_clr), .brk_det(brk_det), .busy(busy),
      .dbg_state(dbg_state)
   );

   // clock / reset-free tick source
   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         b_tick = ~b_tick;
      end
   end

   always @(negedge clk) begin
      if (brk_det === 1'b1) brk_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
      $fatal(1);
   end

   // driver tasks
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic v);
      rx_data = v;
      wait_clks(BIT_CLKS);
   endtask

   // Drives one frame with the current par_mode and records what the receiver should do.
   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_hi);
      logic has_par, perr, brk;
      int   ones;
      has_par = (par_mode == 2'b01) || (par_mode == 2'b10);
      send_bit(1'b0);
      for (int i = 0; i < D_W; i++) send_bit(d[i]);
      if (has_par) send_bit(pbit);
      if (stop_hi) begin
         send_bit(1'b1);
      end else begin
         rx_data = 1'b0;
         wait_clks((B_TICK / 2 + 2) * TDIV);
         rx_data = 1'b1;
         wait_clks((B_TICK / 2 - 2) * TDIV);
      end
      send_bit(1'b1);
      ones = $countones(d) + int'(pbit);
      perr = 1'b0;
      if (par_mode == 2'b01) perr = (ones % 2) == 1;
      if (par_mode == 2'b10) perr = (ones % 2) == 0;
      brk = (d == 8'h00) && (!has_par || !pbit) && !stop_hi;
      if (brk)                        exp_brk++;
      else if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
      else                            exp_q.push_back({!stop_hi, perr, d});
   endtask

   // scoreboard
   task automatic check_state(input string tag);
      @(negedge clk);
      check_eq({tag, ".count"}, 32'(ff_count), exp_q.size());
      check_eq({tag, ".empty"}, ff_empty, exp_q.size() == 0);
      check_eq({tag, ".full"}, ff_full, exp_q.size() == DEPTH);
      check_eq({tag, ".ovr"}, ovr_err, exp_ovr);
      check_eq({tag, ".brk"}, brk_seen, exp_brk);
      if (exp_q.size() != 0) check_eq({tag, ".head"}, {rd_ferr, rd_perr, rd_data}, exp_q[0]);
   endtask

   task automatic pop_check(input string tag);
      @(negedge clk);
      check_eq(tag, {rd_ferr, rd_perr, rd_data}, exp_q[0]);
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      void'(exp_q.pop_front());
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() != 0) pop_check(tag);
      check_state({tag, ".after"});
   endtask

   initial begin
      logic [7:0] d, first;
      int         npop;

      // reset values
      wait_clks(3);
      @(negedge clk);
      check_eq("rst.empty", ff_empty, 1);
      check_eq("rst.full", ff_full, 0);
      check_eq("rst.count", 32'(ff_count), 0);
      check_eq("rst.ovr", ovr_err, 0);
      check_eq("rst.brk", brk_det, 0);
      check_eq("rst.busy", busy, 0);
      check_eq("rst.b_en", b_en, 0);
      check_eq("rst.head", {rd_ferr, rd_perr, rd_data}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_clks(2);
      rx_en = 1'b1;
      wait_clks(2);
      @(negedge clk);
      check_eq("b_en.on", b_en, 1);

      // plain 8N1 frame
      par_mode = 2'b00;
      send_frame(8'hA5, 1'b0, 1'b1);
      check_state("t1");
      check_eq("t1.data", rd_data, 8'hA5);
      check_eq("t1.tags", {rd_ferr, rd_perr}, 2'b00);
      check_eq("t1.count", 32'(ff_count), 1);
      drain("t1");

      // parity: same frame under even and odd
      par_mode = 2'b01;
      send_frame(8'h3C, 1'b1, 1'b1);
      check_state("t2e");
      check_eq("t2e.perr", rd_perr, 1);
      check_eq("t2e.data", rd_data, 8'h3C);
      drain("t2e");
      par_mode = 2'b10;
      send_frame(8'h3C, 1'b1, 1'b1);
      check_state("t2o");
      check_eq("t2o.perr", rd_perr, 0);
      drain("t2o");

      // framing error
      par_mode = 2'b00;
      send_frame(8'h55, 1'b0, 1'b0);
      check_state("t3f");
      check_eq("t3f.ferr", rd_ferr, 1);
      drain("t3f");

      // break: line held low well beyond two frames
      rx_data = 1'b0;
      wait_clks(25 * BIT_CLKS);
      exp_brk++;
      check_state("t3b");
      check_eq("t3b.busy_hold", busy, 1);
      rx_data = 1'b1;
      wait_clks(6);
      @(negedge clk);
      check_eq("t3b.busy_exit", busy, 0);
      check_state("t3b.after");

      // start-bit glitch
      rx_data = 1'b0;
      wait_clks((B_TICK / 4) * TDIV);
      rx_data = 1'b1;
      @(negedge clk);
      check_eq("t5.busy_pulse", busy, 1);
      wait_clks(2 * BIT_CLKS);
      @(negedge clk);
      check_eq("t5.busy_clear", busy, 0);
      check_state("t5");

      // randomised frames with interleaved reads
      for (int n = 0; n < 30; n++) begin
         par_mode = 2'($urandom_range(0, 3));
         d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         send_frame(d, 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
         check_state("rnd");
         npop = $urandom_range(0, 2);
         for (int k = 0; k < npop && exp_q.size() != 0; k++) pop_check("rnd.pop");
      end
      drain("rnd");

      // overrun: DEPTH+1 frames with no reads
      par_mode = 2'b00;
      first = 8'($urandom);
      send_frame(first, 1'b0, 1'b1);
      for (int n = 1; n <= DEPTH; n++) send_frame(8'($urandom) | 8'h01, 1'b0, 1'b1);
      check_state("t4");
      check_eq("t4.full", ff_full, 1);
      check_eq("t4.ovr", ovr_err, 1);
      check_eq("t4.count", 32'(ff_count), DEPTH);
      check_eq("t4.head", rd_data, first);
      @(posedge clk);
      #1;
      ovr_clr = 1'b1;
      wait_clks(1);
      ovr_clr = 1'b0;
      exp_ovr = 1'b0;
      check_state("t4.clr");
      drain("t4");

      // receiver disable inside the data bits
      send_frame(8'h81, 1'b0, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rx_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("t6e.busy", busy, 0);
      check_eq("t6e.b_en", b_en, 0);
      rx_data = 1'b1;
      wait_clks(4);
      rx_en = 1'b1;
      wait_clks(12 * BIT_CLKS);
      check_state("t6e");

      // reset inside the data bits
      send_frame(8'h22, 1'b0, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b0;
      exp_q.delete();
      exp_ovr = 1'b0;
      @(negedge clk);
      check_eq("t6r.count", 32'(ff_count), 0);
      check_eq("t6r.empty", ff_empty, 1);
      check_eq("t6r.busy", busy, 0);
      rx_data = 1'b1;
      wait_clks(3);
      rst = 1'b1;
      wait_clks(12 * BIT_CLKS);
      check_state("t6r.idle");
      send_frame(8'h5A, 1'b0, 1'b1);
      check_state("t6r.post");
      drain("t6r");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
